// File: rtl/control_pkg.sv
// control_pkg: opcode field codes, state enum and decode bundle
// shared by control_decode and control_seq.
package control_pkg;

   typedef enum logic [2:0] {
      LOAD      = 3'b000,
      STORE     = 3'b001,
      ADD       = 3'b010,
      MATCH     = 3'b011,
      LT        = 3'b100,
      DIST      = 3'b101,
      HAS_FUNCA = 3'b110,
      HAS_FUNCB = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      LSL  = 3'b000,
      LSR  = 3'b001,
      INCR = 3'b010,
      AND1 = 3'b011,
      EQZ  = 3'b100,
      ZERO = 3'b101,
      TBD  = 3'b110,
      HALT = 3'b111
   } funca_e;

   typedef enum logic {
      BNO = 1'b0,
      BOF = 1'b1
   } funcb_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      MEMWAIT,
      HALTED
   } state_e;

   typedef struct packed {
      logic rd_mem;
      logic wr_mem;
      logic reg_wr;
      logic mem;
      logic branch;
      logic bof;
      logic flag_upd;
      logic tbd;
      logic halt;
   } dec_t;

endpackage

// File: rtl/control_decode.sv
// control_decode: pure combinational opcode decode.
// in: opcode[OP_W]; out: dec (dec_t strobes and class flags).
module control_decode
   import control_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic [OP_W-1:0] opcode,
   output dec_t            dec
);

   op_e    op;
   funca_e fa;
   funcb_e fb;

   assign op = op_e'(opcode[OP_W-1:OP_W-3]);
   assign fa = funca_e'(opcode[2:0]);
   assign fb = funcb_e'(opcode[2]);

   always_comb begin
      dec = '0;
      unique case (op)
         LOAD: begin
            dec.rd_mem = 1'b1;
            dec.reg_wr = 1'b1;
            dec.mem    = 1'b1;
         end
         STORE: begin
            dec.wr_mem = 1'b1;
            dec.mem    = 1'b1;
         end
         ADD: begin
            dec.reg_wr   = 1'b1;
            dec.flag_upd = 1'b1;
         end
         MATCH, LT, DIST: begin
            dec.reg_wr = 1'b1;
         end
         HAS_FUNCA: begin
            unique case (fa)
               LSL, LSR, INCR: begin
                  dec.reg_wr   = 1'b1;
                  dec.flag_upd = 1'b1;
               end
               AND1, EQZ, ZERO: dec.reg_wr = 1'b1;
               TBD:             dec.tbd    = 1'b1;
               HALT:            dec.halt   = 1'b1;
            endcase
         end
         HAS_FUNCB: begin
            dec.branch = 1'b1;
            dec.bof    = (fb == BOF);
         end
      endcase
   end

endmodule

// File: rtl/control_seq.sv
// control_seq: instruction sequencer FSM with memory wait counter
// and overflow flag. in: Clk Reset Start opcode overflow;
// out: readMem writeMem readOrWriteReg branch taken pcEn stall
// halted illegal (all combinational from state/counter/flag/opcode).
module control_seq
   import control_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int MEM_LAT = 2
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Start,
   input  logic [OP_W-1:0] opcode,
   input  logic            overflow,
   output logic            readMem,
   output logic            writeMem,
   output logic            readOrWriteReg,
   output logic            branch,
   output logic            taken,
   output logic            pcEn,
   output logic            stall,
   output logic            halted,
   output logic            illegal
);

   localparam int CW = $clog2(MEM_LAT) + 1;
   localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);
   localparam bit MULTI = (MEM_LAT > 1);

   state_e        state, nstate;
   logic [CW-1:0] cnt, ncnt;
   logic          ovflag, novflag;
   dec_t          dec;

   control_decode #(.OP_W(OP_W)) u_dec (
      .opcode (opcode),
      .dec    (dec)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= IDLE;
         cnt    <= '0;
         ovflag <= 1'b0;
      end else begin
         state  <= nstate;
         cnt    <= ncnt;
         ovflag <= novflag;
      end
   end

   always_comb begin
      nstate         = state;
      ncnt           = cnt;
      novflag        = ovflag;
      readMem        = 1'b0;
      writeMem       = 1'b0;
      readOrWriteReg = 1'b0;
      branch         = 1'b0;
      taken          = 1'b0;
      pcEn           = 1'b0;
      stall          = 1'b0;
      halted         = 1'b0;
      illegal        = 1'b0;
      unique case (state)
         IDLE: begin
            if (Start) begin
               nstate  = EXEC;
               novflag = 1'b0;
            end
         end
         EXEC: begin
            readMem        = dec.rd_mem;
            writeMem       = dec.wr_mem;
            readOrWriteReg = dec.reg_wr;
            branch         = dec.branch;
            // taken sees the flag as registered, never this cycle's overflow
            taken   = dec.branch & (dec.bof ? ovflag : ~ovflag);
            illegal = dec.tbd;
            if (dec.mem && MULTI) begin
               stall  = 1'b1;
               ncnt   = LAT_M1;
               nstate = MEMWAIT;
            end else if (dec.halt) begin
               nstate = HALTED;
            end else begin
               pcEn = 1'b1;
            end
            if (dec.flag_upd)
               novflag = overflow;
         end
         MEMWAIT: begin
            // opcode is held while pcEn=0, so decode still names the mem op
            readMem        = dec.rd_mem;
            writeMem       = dec.wr_mem;
            readOrWriteReg = dec.reg_wr;
            ncnt           = cnt - ONE;
            if (cnt == ONE) begin
               pcEn   = 1'b1;
               nstate = EXEC;
            end else begin
               stall = 1'b1;
            end
         end
         HALTED: begin
            halted = 1'b1;
            if (Start) begin
               nstate  = EXEC;
               novflag = 1'b0;
            end
         end
      endcase
   end

endmodule
